// File: rtl/latch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : latch_seq_pkg
// Brief   : State encoding, phase-counter sizing and parameter checks for
//           latch_write_sequencer.
// Revision: 1.0
// ============================================================================
package latch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4
  } lws_state_t;

  localparam int LWS_MIN_CYC = 1;

  // One extra bit over the largest phase length keeps CYC-1 in range for any mix.
  function automatic int phase_cnt_width(input int setup_cyc, input int pulse_cyc,
                                         input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return $clog2(m) + 1;
  endfunction

  function automatic bit params_ok(input int setup_cyc, input int pulse_cyc,
                                   input int hold_cyc, input int addr_w, input int depth);
    return (setup_cyc >= LWS_MIN_CYC) && (pulse_cyc >= LWS_MIN_CYC) &&
           (hold_cyc >= LWS_MIN_CYC) && ((1 << addr_w) >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/latch_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : latch_phase_timer
// Brief   : Loadable down-counter with zero flag; holds at zero.
// Revision: 1.0
// ============================================================================
module latch_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : latch_write_sequencer
// Brief   : Setup/enable-pulse/hold write sequencer for a D-latch bank.
//           Optional bank clear sequence under macro LWS_CLEAR_EN.
// Revision: 1.0
// ============================================================================
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [WIDTH-1:0]  IN_DATA,
`ifdef LWS_CLEAR_EN
  input  logic              CLR_REQ,
`endif
  output logic [WIDTH-1:0]  LAT_D,
  output logic [DEPTH-1:0]  LAT_EN,
  output logic              LAT_RST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int C_CNT_W = phase_cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [C_CNT_W-1:0] C_SETUP_LD = C_CNT_W'(SETUP_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_PULSE_LD = C_CNT_W'(PULSE_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_HOLD_LD  = C_CNT_W'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0]    C_DEPTH    = (ADDR_W + 1)'(DEPTH);

  generate
    if (!params_ok(SETUP_CYC, PULSE_CYC, HOLD_CYC, ADDR_W, DEPTH)) begin : g_param_check
      $error("latch_write_sequencer: *_CYC must be >= 1 and 2**ADDR_W >= DEPTH");
    end
  endgenerate

  lws_state_t          r_state, w_state_nxt;
  logic                w_load, w_zero, w_finish, w_accept, w_clr, w_ready_nxt;
  logic [C_CNT_W-1:0]  w_load_val;
  logic [ADDR_W-1:0]   r_addr;
  logic [WIDTH-1:0]    r_data;
  logic                r_bad_addr, r_pend;
  logic [DEPTH-1:0]    w_onehot;

`ifdef LWS_CLEAR_EN
  assign w_clr = (r_state == IDLE) && IN_READY && CLR_REQ;
`else
  assign w_clr = 1'b0;
`endif
  assign w_accept    = (r_state == IDLE) && IN_READY && IN_VALID && !w_clr;
  assign w_ready_nxt = (r_state == IDLE) && !w_accept && !w_clr;
  assign w_onehot    = DEPTH'(1) << r_addr;

  latch_phase_timer #(.CNT_W(C_CNT_W)) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_zero    (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_clr) begin
          w_state_nxt = CLEAR;
          w_load      = 1'b1;
          w_load_val  = C_PULSE_LD;
        end else if (w_accept) begin
          w_state_nxt = SETUP;
          w_load      = 1'b1;
          w_load_val  = C_SETUP_LD;
        end
      end
      SETUP: if (w_zero) begin
        w_state_nxt = PULSE;
        w_load      = 1'b1;
        w_load_val  = C_PULSE_LD;
      end
      PULSE: if (w_zero) begin
        w_state_nxt = HOLD;
        w_load      = 1'b1;
        w_load_val  = C_HOLD_LD;
      end
      HOLD: if (w_zero) begin
        w_state_nxt = IDLE;
        w_finish    = 1'b1;
      end
`ifdef LWS_CLEAR_EN
      CLEAR: if (w_zero) begin
        w_state_nxt = IDLE;
        w_finish    = 1'b1;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Outputs are a registered image of the current state, one edge behind it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_bad_addr <= 1'b0;
      r_pend     <= 1'b0;
      IN_READY   <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      LAT_RST    <= 1'b0;
      LAT_D      <= '0;
      LAT_EN     <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= IN_ADDR;
        r_data     <= IN_DATA;
        r_bad_addr <= ({1'b0, IN_ADDR} >= C_DEPTH);
      end
      r_pend   <= w_finish;
      IN_READY <= w_ready_nxt;
      BUSY     <= !w_ready_nxt;
      DONE     <= r_pend;
      ERR      <= r_pend && r_bad_addr;
      LAT_RST  <= (r_state != CLEAR);
      if (r_state == SETUP) LAT_D <= r_data;
      LAT_EN   <= ((r_state == PULSE) && !r_bad_addr) ? w_onehot : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_latch_write_sequencer
// Brief   : Self-checking bench: DEPTH=4 and DEPTH=3 instances on shared inputs
//           against a timeline model of the write/clear sequences.
// Revision: 1.0
// ============================================================================
module tb_latch_write_sequencer;

  localparam int S = 1, P = 2, H = 1, T = S + P + H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid;
  logic [1:0] in_addr;
  logic [7:0] in_data;
`ifdef LWS_CLEAR_EN
  logic       clr_req;
`endif
  logic       ready, busy, done, err, lrst;
  logic [7:0] dd;
  logic [3:0] en;
  logic       ready3, busy3, done3, err3, lrst3;
  logic [7:0] d3;
  logic [2:0] en3;

  int n_tests, n_fail;

  latch_write_sequencer u_dut (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .IN_READY(ready), .IN_ADDR(in_addr),
    .IN_DATA(in_data),
`ifdef LWS_CLEAR_EN
    .CLR_REQ(clr_req),
`endif
    .LAT_D(dd), .LAT_EN(en), .LAT_RST(lrst), .BUSY(busy), .DONE(done), .ERR(err)
  );

  latch_write_sequencer #(.DEPTH(3)) u_dut3 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .IN_READY(ready3), .IN_ADDR(in_addr),
    .IN_DATA(in_data),
`ifdef LWS_CLEAR_EN
    .CLR_REQ(clr_req),
`endif
    .LAT_D(d3), .LAT_EN(en3), .LAT_RST(lrst3), .BUSY(busy3), .DONE(done3), .ERR(err3)
  );

  // Timeline model: everything is derived from the edge distance k since the last accept/clear.
  int         e, acc_e, clr_e, m_addr;
  bit         m_ready, m_lrst, x_done, x_err4, x_err3;
  logic [7:0] m_data, m_d;
  logic [3:0] x_en4;
  logic [2:0] x_en3;

  logic [32:0] act_v, exp_v;
  assign act_v = {ready, busy, done, err, lrst, dd, en, ready3, busy3, done3, err3, lrst3, d3, en3};
  assign exp_v = {m_ready, !m_ready, x_done, x_err4, m_lrst, m_d, x_en4,
                  m_ready, !m_ready, x_done, x_err3, m_lrst, m_d, x_en3};

  task automatic model_reset();
    e = 0; acc_e = -1; clr_e = -1; m_addr = 0; m_ready = 0; m_lrst = 0;
    x_done = 0; x_err4 = 0; x_err3 = 0; m_data = '0; m_d = '0; x_en4 = '0; x_en3 = '0;
  endtask

  task automatic model_edge();
    bit was, clr_eff;
    int k;
`ifdef LWS_CLEAR_EN
    clr_eff = clr_req;
`else
    clr_eff = 1'b0;
`endif
    e++;
    was = m_ready;
    if (was && clr_eff) begin
      clr_e = e; acc_e = -1; m_ready = 0;
    end else if (was && in_valid) begin
      acc_e = e; clr_e = -1; m_data = in_data; m_addr = int'(in_addr); m_ready = 0;
    end else if (!was) begin
      if (e == 1) m_ready = 1;
      else if (acc_e >= 0 && e - acc_e == T + 1) m_ready = 1;
      else if (clr_e >= 0 && e - clr_e == P + 1) m_ready = 1;
    end
    m_lrst = 1; x_done = 0; x_err4 = 0; x_err3 = 0; x_en4 = '0; x_en3 = '0;
    if (acc_e >= 0) begin
      k = e - acc_e;
      if (k == 1) m_d = m_data;
      if (k >= S + 1 && k <= S + P) begin
        if (m_addr < 4) x_en4 = 4'b0001 << m_addr;
        if (m_addr < 3) x_en3 = 3'b001 << m_addr;
      end
      if (k == T + 1) begin
        x_done = 1; x_err4 = (m_addr >= 4); x_err3 = (m_addr >= 3);
      end
    end
    if (clr_e >= 0) begin
      k = e - clr_e;
      if (k >= 1 && k <= P) m_lrst = 0;
      if (k == P + 1) x_done = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_addr = '0; in_data = '0;
`ifdef LWS_CLEAR_EN
    clr_req = 0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (lrst !== 1'b0)  begin n_fail++; $display("FAIL rst_lat_rst: got %b want 0", lrst); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_tests++; if ({en, dd, done, err, busy} !== 15'd0)
      begin n_fail++; $display("FAIL rst_outputs: got en=%h d=%h done=%b err=%b busy=%b want 0", en, dd, done, err, busy); end
    rst_n = 1;
    tick();
    n_tests++; if (lrst !== 1'b1)  begin n_fail++; $display("FAIL release_lat_rst: got %b want 1", lrst); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++; if (en !== 4'd0 || done !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL idle_quiet: got en=%h done=%b busy=%b want 0", en, done, busy); end
    end
  endtask

  task automatic test_single_write();
    in_addr = 2'd2; in_data = 8'hA5; in_valid = 1;
    tick();
    in_valid = 0;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL accept_ready_drop: got %b want 0", ready); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_tests++; if ({dd, en, done, err} !== {m_d, x_en4, x_done, x_err4})
        begin n_fail++; $display("FAIL single_k%0d: got d=%h en=%b done=%b err=%b want d=%h en=%b done=%b err=%b",
                                 k, dd, en, done, err, m_d, x_en4, x_done, x_err4); end
      if (k == 1) begin
        n_tests++; if (dd !== 8'hA5) begin n_fail++; $display("FAIL single_setup_data: got %h want a5", dd); end
      end
      if (k == 5) begin
        n_tests++; if ({done, err, ready} !== 3'b101)
          begin n_fail++; $display("FAIL single_done_at_5: got done/err/ready=%b want 101", {done, err, ready}); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int addrs[3] = '{0, 1, 3};
    logic [3:0] seen[3];
    logic [3:0] prev_en = '0;
    logic [7:0] prev_d = '0;
    int idx = 0, pulses = 0;
    in_valid = 1;
    for (int c = 0; c < 30; c++) begin
      if (idx < 3) begin in_addr = 2'(addrs[idx]); in_data = 8'($urandom); end
      else in_valid = 0;
      tick();
      if (acc_e == e) idx++;
      n_tests++; if (act_v !== exp_v)
        begin n_fail++; $display("FAIL b2b_c%0d: got %h want %h", c, act_v, exp_v); end
      if (en != 4'd0 && prev_en == 4'd0) begin
        if (pulses < 3) seen[pulses] = en;
        pulses++;
      end
      if (en != 4'd0 && prev_en != 4'd0) begin
        n_tests++; if (dd !== prev_d)
          begin n_fail++; $display("FAIL b2b_d_stable: got %h want %h", dd, prev_d); end
      end
      prev_en = en; prev_d = dd;
    end
    in_valid = 0;
    n_tests++; if (pulses != 3 || seen[0] !== 4'b0001 || seen[1] !== 4'b0010 || seen[2] !== 4'b1000)
      begin n_fail++; $display("FAIL b2b_pulses: got %0d pulses want 3 (0001,0010,1000)", pulses); end
  endtask

  task automatic test_out_of_range();
    in_addr = 2'd3; in_data = 8'h5A; in_valid = 1;
    tick();
    in_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_tests++; if (en3 !== 3'd0) begin n_fail++; $display("FAIL oor_en_k%0d: got %b want 000", k, en3); end
      n_tests++; if ({done3, err3, en, err} !== {x_done, x_err3, x_en4, x_err4})
        begin n_fail++; $display("FAIL oor_k%0d: got done3=%b err3=%b en4=%b err4=%b want %b %b %b %b",
                                 k, done3, err3, en, err, x_done, x_err3, x_en4, x_err4); end
      if (k == 5) begin
        n_tests++; if ({done3, err3} !== 2'b11)
          begin n_fail++; $display("FAIL oor_done_err_at_5: got %b want 11", {done3, err3}); end
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit found = 0;
    in_addr = 2'd1; in_data = 8'($urandom); in_valid = 1;
    tick();
    in_valid = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (x_en4 != 4'd0) begin found = 1; break; end
    end
    n_tests++; if (!found || en !== 4'b0010)
      begin n_fail++; $display("FAIL pulse_before_reset: got %b want 0010", en); end
    rst_n = 0;
    #1;
    n_tests++; if ({en, en3} !== 7'd0) begin n_fail++; $display("FAIL async_en_drop: got %b want 0", {en, en3}); end
    n_tests++; if (lrst !== 1'b0)      begin n_fail++; $display("FAIL async_lat_rst: got %b want 0", lrst); end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1;
    tick();
    n_tests++; if ({ready, busy, lrst, en} !== 7'b1010000)
      begin n_fail++; $display("FAIL rerelease: got ready/busy/lrst/en=%b want 1010000", {ready, busy, lrst, en}); end
  endtask

`ifdef LWS_CLEAR_EN
  task automatic test_clear();
    int lows = 0, dones = 0;
    bit saw_en = 0;
    in_addr = 2'd2; in_data = 8'h3C; in_valid = 1; clr_req = 1;
    tick();
    clr_req = 0;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready_drop: got %b want 0", ready); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (acc_e == e) in_valid = 0;
      n_tests++; if (act_v !== exp_v)
        begin n_fail++; $display("FAIL clear_c%0d: got %h want %h", c, act_v, exp_v); end
      if (lrst === 1'b0) lows++;
      if (done === 1'b1) dones++;
      if (en === 4'b0100) saw_en = 1;
    end
    in_valid = 0;
    n_tests++; if (lows != 2 || dones != 2 || !saw_en)
      begin n_fail++; $display("FAIL clear_summary: got lows=%0d dones=%0d en=%b want 2 2 1", lows, dones, saw_en); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_addr  = 2'($urandom);
      in_data  = 8'($urandom);
`ifdef LWS_CLEAR_EN
      clr_req  = ($urandom_range(0, 9) == 0);
`endif
      tick();
      n_tests++; if (act_v !== exp_v)
        begin n_fail++; $display("FAIL random_c%0d: got %h want %h", c, act_v, exp_v); end
    end
    in_valid = 0;
`ifdef LWS_CLEAR_EN
    clr_req = 0;
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_pulse();
`ifdef LWS_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
